// File: rtl/conv_mem_host.sv
// Memory-side responder for the CONV5x5 engine: image ROM, Layer0/Layer1 result RAMs,
// run handshake FSM with timeout, and a host load/readback/status port.
module conv_mem_host #(
    parameter int DW        = 13,
    parameter int AW        = 12,
    parameter int IMG_DEPTH = 4096,
    parameter int L0_DEPTH  = 4096,
    parameter int L1_DEPTH  = 1024,
    parameter int TIMEOUT   = 10000000,
    parameter int CW        = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          rb_sel,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_data,
    output logic          done,
    output logic          timeout_err,
    output logic          range_err,
    output logic [CW-1:0] run_cycles,
    output logic [12:0]   wr_cnt0,
    output logic [10:0]   wr_cnt1,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic          csel,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd
);

    localparam int IMG_AW = $clog2(IMG_DEPTH);
    localparam int L0_AW  = $clog2(L0_DEPTH);
    localparam int L1_AW  = $clog2(L1_DEPTH);
    localparam logic [AW:0]   L1_LIM  = (AW+1)'(L1_DEPTH);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RUN, DONE} state_t;

    state_t state, state_nxt;
    logic   run_act;

    logic [DW-1:0] img [IMG_DEPTH];
    logic [DW-1:0] l0  [L0_DEPTH];
    logic [DW-1:0] l1  [L1_DEPTH];

    logic          img_we, l0_we, l1_we;
    logic          l1_wr_oob, l1_rd_oob, rb_oob;
    logic [DW-1:0] rd_word, rd_hold, rb_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = REQ;
            REQ:  if (busy) state_nxt = RUN;
            RUN:  if (!busy || run_cycles == TO_LAST) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready   = 1'b0;
        done    = 1'b0;
        run_act = 1'b0;
        case (state)
            REQ:  ready   = 1'b1;
            RUN:  run_act = 1'b1;
            DONE: done    = 1'b1;
            default: ;
        endcase
    end

    // Out-of-range Layer1 accesses never touch the array, so low address bits cannot alias.
    assign l1_wr_oob = cwr && csel && ({1'b0, caddr_wr} >= L1_LIM);
    assign l1_rd_oob = csel && ({1'b0, caddr_rd} >= L1_LIM);
    assign rb_oob    = rb_sel && ({1'b0, rb_addr} >= L1_LIM);

    assign img_we = (state == IDLE) && ld_we;
    assign l0_we  = run_act && cwr && !csel;
    assign l1_we  = run_act && cwr && csel && !l1_wr_oob;

    assign idata   = run_act ? img[iaddr[IMG_AW-1:0]] : '0;
    assign rd_word = csel ? (l1_rd_oob ? '0 : l1[caddr_rd[L1_AW-1:0]])
                          : l0[caddr_rd[L0_AW-1:0]];
    assign rb_word = rb_sel ? (rb_oob ? '0 : l1[rb_addr[L1_AW-1:0]])
                            : l0[rb_addr[L0_AW-1:0]];
    assign cdata_rd = crd ? rd_word : rd_hold;

    always_ff @(posedge clk) begin
        if (img_we) img[ld_addr[IMG_AW-1:0]] <= ld_data;
        if (l0_we)  l0[caddr_wr[L0_AW-1:0]]  <= cdata_wr;
        if (l1_we)  l1[caddr_wr[L1_AW-1:0]]  <= cdata_wr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cycles  <= '0;
            wr_cnt0     <= '0;
            wr_cnt1     <= '0;
            timeout_err <= 1'b0;
            range_err   <= 1'b0;
            rd_hold     <= '0;
            rb_data     <= '0;
        end else begin
            // Status of the previous run survives until the next start is accepted.
            if (state == IDLE && start) begin
                run_cycles  <= '0;
                wr_cnt0     <= '0;
                wr_cnt1     <= '0;
                timeout_err <= 1'b0;
                range_err   <= 1'b0;
            end else begin
                if (run_act) run_cycles <= run_cycles + CW'(1);
                if (run_act && busy && run_cycles == TO_LAST) timeout_err <= 1'b1;
                if (l0_we) wr_cnt0 <= wr_cnt0 + 13'd1;
                if (l1_we) wr_cnt1 <= wr_cnt1 + 11'd1;
                if ((run_act && l1_wr_oob) || (crd && l1_rd_oob)) range_err <= 1'b1;
            end
            if (crd) rd_hold <= rd_word;
            rb_data <= rb_word;
        end
    end

endmodule

// File: tb/tb_conv_mem_host.sv
// Directed bench for conv_mem_host: handshake, image serving, layer read/write,
// range errors, readback, async reset mid-run, and timeout on a short-TIMEOUT instance.
module tb_conv_mem_host;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start_t, ld_we, rb_sel, busy, busy_t, cwr, csel, crd;
    logic [11:0] ld_addr, rb_addr, iaddr, caddr_wr, caddr_rd;
    logic [12:0] ld_data, cdata_wr;

    logic [12:0] rb_data, idata, cdata_rd;
    logic        done, timeout_err, range_err, ready;
    logic [31:0] run_cycles;
    logic [12:0] wr_cnt0;
    logic [10:0] wr_cnt1;

    logic [12:0] rb_data_t, idata_t, cdata_rd_t;
    logic        done_t, timeout_err_t, range_err_t, ready_t;
    logic [31:0] run_cycles_t;
    logic [12:0] wr_cnt0_t;
    logic [10:0] wr_cnt1_t;

    int total = 0;
    int bad   = 0;
    int ticks = 0;
    int rs, n;
    logic seen;

    always #5 clk = ~clk;

    conv_mem_host u0 (
        .clk(clk), .reset(reset), .start(start), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_data(ld_data), .rb_sel(rb_sel), .rb_addr(rb_addr), .rb_data(rb_data),
        .done(done), .timeout_err(timeout_err), .range_err(range_err),
        .run_cycles(run_cycles), .wr_cnt0(wr_cnt0), .wr_cnt1(wr_cnt1), .ready(ready),
        .busy(busy), .iaddr(iaddr), .idata(idata), .cwr(cwr), .csel(csel),
        .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd),
        .cdata_rd(cdata_rd)
    );

    conv_mem_host #(.TIMEOUT(100)) u1 (
        .clk(clk), .reset(reset), .start(start_t), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_data(ld_data), .rb_sel(rb_sel), .rb_addr(rb_addr), .rb_data(rb_data_t),
        .done(done_t), .timeout_err(timeout_err_t), .range_err(range_err_t),
        .run_cycles(run_cycles_t), .wr_cnt0(wr_cnt0_t), .wr_cnt1(wr_cnt1_t), .ready(ready_t),
        .busy(busy_t), .iaddr(iaddr), .idata(idata_t), .cwr(cwr), .csel(csel),
        .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd),
        .cdata_rd(cdata_rd_t)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        ticks++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; start = 0; start_t = 0; ld_we = 0; rb_sel = 0; busy = 0; busy_t = 0;
        cwr = 0; csel = 0; crd = 0; ld_addr = '0; rb_addr = '0; iaddr = '0;
        caddr_wr = '0; caddr_rd = '0; ld_data = '0; cdata_wr = '0;

        // reset state
        tick(); tick();
        chk("rst_ready", ready, 0);
        chk("rst_done", done, 0);
        chk("rst_rb_data", rb_data, 0);
        chk("rst_cdata_rd", cdata_rd, 0);
        chk("rst_errs", {timeout_err, range_err}, 0);
        chk("rst_counts", {run_cycles, wr_cnt0, wr_cnt1} == '0, 1);
        reset = 1'b1;
        tick();

        // image load
        for (int k = 0; k < 4096; k++) begin
            ld_we = 1; ld_addr = 12'(k); ld_data = 13'(k & 13'h1FFF);
            tick();
        end
        ld_we = 0;

        // run 1: handshake, image serving, small read/write checks
        start = 1; tick(); start = 0;
        chk("req_ready", ready, 1);
        iaddr = 12'h123; #1;
        chk("idata_not_run", idata, 0);
        busy = 1; tick(); rs = ticks;
        chk("run_ready_low", ready, 0);
        chk("idata_123", idata, 13'h123);
        ld_we = 1; ld_addr = 12'h123; ld_data = 13'h555;
        cwr = 1; csel = 0; caddr_wr = 12'd5; cdata_wr = 13'h0AB;
        tick();
        ld_we = 0; cwr = 0; crd = 1; caddr_rd = 12'd5; #1;
        chk("crd_comb", cdata_rd, 13'h0AB);
        chk("ld_we_ignored_run", idata, 13'h123);
        tick(); crd = 0; #1;
        chk("crd_hold", cdata_rd, 13'h0AB);
        chk("wr_cnt0_one", wr_cnt0, 1);
        cwr = 1; caddr_wr = 12'd5; cdata_wr = 13'h111; crd = 1; #1;
        chk("rdw_comb_old", cdata_rd, 13'h0AB);
        tick(); cwr = 0; crd = 0; #1;
        chk("rdw_hold_old", cdata_rd, 13'h0AB);
        crd = 1; #1;
        chk("rdw_new", cdata_rd, 13'h111);
        crd = 0;
        busy = 0; tick();
        chk("run1_done", done, 1);
        chk("run1_cycles", run_cycles, 32'(ticks - rs));
        tick();
        chk("run1_done_low", done, 0);
        chk("run1_wr_cnt0", wr_cnt0, 2);

        // run 2: full layer fill, Layer1 range error
        start = 1; tick(); start = 0;
        chk("run2_cnt_clear", wr_cnt0, 0);
        chk("run2_cyc_clear", run_cycles, 0);
        busy = 1; tick(); rs = ticks;
        for (int k = 0; k < 4096; k++) begin
            cwr = 1; csel = 0; caddr_wr = 12'(k); cdata_wr = 13'(k * 3 + 7);
            tick();
        end
        for (int k = 0; k < 1024; k++) begin
            cwr = 1; csel = 1; caddr_wr = 12'(k); cdata_wr = 13'(k ^ 13'h1555);
            tick();
        end
        chk("range_err_before", range_err, 0);
        caddr_wr = 12'd1024; cdata_wr = 13'h0777; tick(); cwr = 0;
        chk("range_err_wr", range_err, 1);
        chk("oob_wr_not_counted", wr_cnt1, 1024);
        crd = 1; csel = 1; caddr_rd = 12'd0; #1;
        chk("l1_0_unchanged", cdata_rd, 13'h1555);
        caddr_rd = 12'd1024; #1;
        chk("l1_oob_rd_zero", cdata_rd, 0);
        crd = 0;
        busy = 0; tick();
        chk("run2_done", done, 1);
        chk("run2_cycles", run_cycles, 32'(ticks - rs));
        chk("run2_no_timeout", timeout_err, 0);
        tick();
        chk("run2_done_low", done, 0);
        chk("run2_wr_cnt0", wr_cnt0, 4096);
        chk("run2_wr_cnt1", wr_cnt1, 1024);
        chk("range_err_sticky", range_err, 1);
        rb_sel = 1; rb_addr = 12'd1023; tick();
        chk("rb_l1_1023", rb_data, 13'h16AA);
        rb_sel = 0; rb_addr = 12'd4095; tick();
        chk("rb_l0_4095", rb_data, 13'h1004);

        // run 3: async reset during RUN
        start = 1; tick(); start = 0;
        chk("range_err_cleared", range_err, 0);
        busy = 1; tick();
        #2 reset = 1'b0; #1;
        chk("arst_ready", ready, 0);
        chk("arst_done", done, 0);
        chk("arst_cycles", run_cycles, 0);
        tick(); reset = 1'b1;
        tick();
        chk("arst_idle_ready", ready, 0);
        chk("arst_idle_done", done, 0);
        rb_sel = 0; rb_addr = 12'd5; tick();
        chk("arst_l0_5", rb_data, 13'h016);
        rb_addr = 12'd4095; tick();
        chk("arst_l0_4095", rb_data, 13'h1004);
        busy = 0;

        // timeout on the TIMEOUT=100 instance
        start_t = 1; tick(); start_t = 0;
        busy_t = 1;
        n = 0; seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick(); n++;
            if (done_t) seen = 1;
        end
        chk("to_done_seen", seen, 1);
        chk("to_latency", n, 101);
        chk("to_err", timeout_err_t, 1);
        chk("to_cycles", run_cycles_t, 100);
        tick();
        chk("to_done_low", done_t, 0);
        tick();
        chk("to_idle_ready", ready_t, 0);
        chk("to_err_sticky", timeout_err_t, 1);
        busy_t = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_mem_host.md
Name: conv_mem_host

Overview:
- Synthesizable responder for the CONV5x5 engine's image and layer-memory interface.
- Starts the engine through the ready/busy handshake and serves image pixels on iaddr/idata.
- Owns the Layer0 and Layer1 result memories and services the engine's write (cwr) and read (crd) requests.
- Provides a host-side port to load the image before a run, read results back after it, and report run status.

Parameters:
- DW, 13, pixel/result data width
- AW, 12, address width
- IMG_DEPTH, 4096, image memory words
- L0_DEPTH, 4096, Layer0 memory words
- L1_DEPTH, 1024, Layer1 memory words
- TIMEOUT, 10000000, maximum RUN cycles before abort
- CW, 32, cycle counter width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous active-low reset (0 = reset)
- start  in  1  host pulse; begins a run when in IDLE
- ld_we  in  1  host image write enable; accepted only in IDLE
- ld_addr  in  AW  host image write address
- ld_data  in  DW  host image write data
- rb_sel  in  1  readback select: 0 = Layer0, 1 = Layer1
- rb_addr  in  AW  readback address
- rb_data  out  DW  readback data, registered, 1-cycle latency
- done  out  1  one-cycle pulse when a run ends (normal or abort)
- timeout_err  out  1  sticky; run aborted by TIMEOUT
- range_err  out  1  sticky; Layer1 access with address >= L1_DEPTH
- run_cycles  out  CW  cycles spent in RUN for the last run
- wr_cnt0  out  13  Layer0 writes in the last run
- wr_cnt1  out  11  Layer1 writes in the last run
- ready  out  1  to engine; start request
- busy  in  1  from engine
- iaddr  in  AW  engine image address
- idata  out  DW  image data
- cwr  in  1  engine write strobe
- csel  in  1  engine layer select: 0 = Layer0, 1 = Layer1
- caddr_wr  in  AW  engine write address
- cdata_wr  in  DW  engine write data
- crd  in  1  engine read strobe
- caddr_rd  in  AW  engine read address
- cdata_rd  out  DW  engine read data

Behaviour:
- Reset values: ready=0, done=0, rb_data=0, cdata_rd hold register=0, all error flags=0, all counters=0, FSM=IDLE. Memory contents are not cleared.
- FSM states and transitions:
  - IDLE: start=1 -> REQ. On entry to REQ, clear wr_cnt0, wr_cnt1, run_cycles and both error flags.
  - REQ: ready=1. When busy=1 is sampled, ready drops to 0 in the same edge -> RUN.
  - RUN: run_cycles increments each cycle. busy=0 sampled -> DONE. run_cycles == TIMEOUT-1 -> timeout_err=1, go to DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- start outside IDLE is ignored. ld_we outside IDLE is ignored (no write).
- idata is a combinational read of image[iaddr] when FSM=RUN, else 0. An address issued at edge N is valid for sampling at edge N+1 (zero wait states).
- cwr=1 in RUN writes cdata_wr to Layer[csel][caddr_wr] at the rising edge and increments the matching wr_cnt. Layer1 with caddr_wr >= L1_DEPTH: write dropped, range_err set. cwr outside RUN is ignored.
- cdata_rd:
  - crd=1: combinational Layer[csel][caddr_rd], captured into the hold register at the edge.
  - crd=0: the hold register value.
  - Read-during-write to the same location returns the old data.
  - A Layer1 read with caddr_rd >= L1_DEPTH returns 0 and sets range_err.
- Simultaneous ld_we, cwr and rb access is legal. Readback is served in any state; rb_data = Layer[rb_sel][rb_addr] registered.
- Asynchronous reset mid-run forces IDLE and ready=0 immediately. No done pulse is produced.
- busy already 1 on entry to REQ: RUN is reached on the next edge.

Test Plan:
- Load image[k] = k & 0x1FFF for all 4096 words, pulse start -> ready=1 the cycle after start; ready=0 on the edge busy is sampled high; then iaddr=0x123 gives idata=0x123 before the next edge.
- In RUN, cwr csel=0 addr=5 data=0x0AB, then crd csel=0 addr=5 the next cycle -> cdata_rd=0x0AB; cdata_rd holds 0x0AB after crd falls; wr_cnt0=1.
- Engine writes all 4096 Layer0 and all 1024 Layer1 words, then drops busy -> done pulse of exactly one cycle; wr_cnt0=4096, wr_cnt1=1024; readback rb_sel=1 rb_addr=1023 returns the written value one cycle later.
- cwr csel=1 addr=1024 -> Layer1 unchanged, range_err=1 and sticky until the next start.
- TIMEOUT=100 with busy held 1 -> timeout_err=1 and done pulse at run_cycles=100; FSM returns to IDLE.
- Assert reset low during RUN -> ready=0, done=0, FSM=IDLE; Layer0 contents still readable and unchanged.
